dmem_responder: RTL and testbench

//  Data-memory responder for the memory stage: the target end of the load/store interface the pipeline drives.

---
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target for the memory stage.
// One request at a time, WAIT_CYCLES wait states, then a one-cycle response.
//
// Handshake: a request is accepted on a rising edge where ReqValidM and
// ReqReadyM are both high. ReqReadyM is high only in IDLE and never while
// rst is high. RespValidM is a one-cycle strobe; ReadDataM and ErrM are
// meaningful only while it is high and read as 0 otherwise. The requester
// keeps ReqValidM high until it sees RespValidM. StallM = ReqValidM & ~RespValidM.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqValidM,
  input  logic        MemWriteM,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  ByteEnM,
  output logic        ReqReadyM,
  output logic        RespValidM,
  output logic [31:0] ReadDataM,
  output logic        ErrM,
  output logic        StallM,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        resp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem_q [0:(1 << ADDR_WIDTH) - 1];

  logic                  accept;
  logic                  enter_resp;
  logic                  use_live;
  logic [31:0]           eff_addr;
  logic [31:0]           eff_wdata;
  logic [3:0]            eff_be;
  logic                  eff_we;
  logic                  eff_err;
  logic [ADDR_WIDTH-1:0] eff_idx;

  // Handshake, and the payload of the access being completed: the live inputs
  // when there are no wait states (RESP entered on the accept edge itself),
  // otherwise the copy latched at accept.
  always_comb begin
    ReqReadyM  = (state_q == S_IDLE) && !rst;
    accept     = ReqValidM && ReqReadyM;
    use_live   = (state_q == S_IDLE);
    eff_addr   = use_live ? ALU_ResultM : addr_q;
    eff_wdata  = use_live ? WriteDataM  : wdata_q;
    eff_be     = use_live ? ByteEnM     : be_q;
    eff_we     = use_live ? MemWriteM   : we_q;
    eff_idx    = eff_addr[ADDR_WIDTH+1:2];
    eff_err    = (eff_addr[1:0] != 2'b00) || ((eff_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    enter_resp = !rst && ((accept && NO_WAIT) || ((state_q == S_WAIT) && (cnt_q == 4'd0)));
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= ALU_ResultM;
            wdata_q <= WriteDataM;
            be_q    <= ByteEnM;
            we_q    <= MemWriteM;
            cnt_q   <= WAIT_LOAD;
            state_q <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
      // Response contents are captured on the edge that enters RESP.
      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        err_q        <= eff_err;
        rdata_q      <= (!eff_err && !eff_we) ? mem_q[eff_idx] : 32'd0;
      end
    end
  end

  // Byte-masked store commit on the edge entering RESP; the array is never reset.
  always_ff @(posedge clk) begin
    if (enter_resp && eff_we && !eff_err) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_be[i]) mem_q[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
      end
    end
  end

  // Output wiring.
  always_comb begin
    RespValidM  = resp_valid_q;
    ReadDataM   = rdata_q;
    ErrM        = err_q;
    StallM      = ReqValidM && !resp_valid_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A (WAIT_CYCLES=2) for the main
// load/store/error/reset sequence, instance B (WAIT_CYCLES=0) for back-to-back.
module tb_dmem_responder;

  localparam int W_A = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A signals
  logic        a_valid = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = 32'd0, a_wdata = 32'd0;
  logic [3:0]  a_be = 4'd0;
  logic        a_ready, a_rvalid, a_err, a_stall;
  logic [31:0] a_rdata;
  logic [1:0]  a_state;

  // Instance B signals
  logic        b_valid = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = 32'd0, b_wdata = 32'd0;
  logic [3:0]  b_be = 4'd0;
  logic        b_ready, b_rvalid, b_err, b_stall;
  logic [31:0] b_rdata;
  logic [1:0]  b_state;

  // Scoreboard entries: {check_data, err, data}
  logic [33:0] exp_q[$];

  int passed = 0;
  int total  = 0;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W_A)) dut_a (
    .clk(clk), .rst(rst), .ReqValidM(a_valid), .MemWriteM(a_we),
    .ALU_ResultM(a_addr), .WriteDataM(a_wdata), .ByteEnM(a_be),
    .ReqReadyM(a_ready), .RespValidM(a_rvalid), .ReadDataM(a_rdata),
    .ErrM(a_err), .StallM(a_stall), .dbg_state_o(a_state)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .ReqValidM(b_valid), .MemWriteM(b_we),
    .ALU_ResultM(b_addr), .WriteDataM(b_wdata), .ByteEnM(b_be),
    .ReqReadyM(b_ready), .RespValidM(b_rvalid), .ReadDataM(b_rdata),
    .ErrM(b_err), .StallM(b_stall), .dbg_state_o(b_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One access on instance A; called just after a rising edge with A idle.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic exp_err, input logic [31:0] exp_data,
                           input logic chk_data);
    logic [33:0] e;
    int n;
    logic got;
    exp_q.push_back({chk_data, exp_err, exp_data});
    a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
    #1;
    check("ready_idle", 32'(a_ready), 32'd1);
    check("stall_req", 32'(a_stall), 32'd1);
    @(posedge clk); #1;
    // Scramble payload after accept: the latched copy must be used.
    a_addr = ~addr; a_wdata = ~wdata; a_be = ~be; a_we = ~we;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      if (a_rvalid) got = 1'b1;
      else begin
        check("stall_wait", 32'(a_stall), 32'd1);
        check("ready_wait", 32'(a_ready), 32'd0);
        @(posedge clk); #1;
        n++;
      end
    end
    check("resp_seen", 32'(got), 32'd1);
    e = exp_q.pop_front();
    if (got) begin
      check("latency", 32'(n), 32'(W_A));
      check("err", 32'(a_err), 32'(e[32]));
      if (e[33]) check("rdata", a_rdata, e[31:0]);
      check("stall_resp", 32'(a_stall), 32'd0);
      check("ready_resp", 32'(a_ready), 32'd0);
    end
    a_valid = 1'b0;
    @(posedge clk); #1;
    check("rvalid_after", 32'(a_rvalid), 32'd0);
    check("rdata_after", a_rdata, 32'd0);
    check("err_after", 32'(a_err), 32'd0);
    check("ready_after", 32'(a_ready), 32'd1);
  endtask

  // Directed sequence
  initial begin
    logic [31:0] d0, d1, merged, ad;
    logic [3:0]  be;

    // Reset: a request held during reset must not be accepted.
    a_valid = 1'b1; a_addr = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_rvalid", 32'(a_rvalid), 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_state", 32'(a_state), 32'd0);
    check("rst_ready_b", 32'(b_ready), 32'd0);
    a_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(a_ready), 32'd1);
    check("post_rst_rvalid", 32'(a_rvalid), 32'd0);

    // 1-3: store, load, partial store, zero-enable store
    do_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0, 1'b0);
    do_access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    do_access(1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b0, 32'd0, 1'b0);
    do_access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEAA, 1'b1);
    do_access(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'd0, 1'b0);
    do_access(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEAA, 1'b1);

    // 4: misaligned load, out-of-range store (aliases word 0), word 0 intact
    do_access(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, 32'd0, 1'b0);
    do_access(1'b0, 32'h12, 32'h0, 4'hF, 1'b1, 32'd0, 1'b1);
    do_access(1'b1, 32'h00001000, 32'h11111111, 4'hF, 1'b1, 32'd0, 1'b1);
    do_access(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 1'b1);

    // Random byte-merge patterns
    for (int i = 0; i < 4; i++) begin
      ad = 32'h100 + 32'(4 * i);
      d0 = $urandom; d1 = $urandom;
      be = 4'($urandom_range(1, 14));
      for (int b = 0; b < 4; b++) merged[8*b +: 8] = be[b] ? d1[8*b +: 8] : d0[8*b +: 8];
      do_access(1'b1, ad, d0, 4'hF, 1'b0, 32'd0, 1'b0);
      do_access(1'b1, ad, d1, be, 1'b0, 32'd0, 1'b0);
      do_access(1'b0, ad, 32'h0, 4'h0, 1'b0, merged, 1'b1);
    end

    // 6: reset during WAIT abandons the store
    do_access(1'b1, 32'h20, 32'h55AA55AA, 4'hF, 1'b0, 32'd0, 1'b0);
    a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h12345678; a_be = 4'hF;
    @(posedge clk); #1;
    check("abort_in_wait", 32'(a_state), 32'd1);
    rst = 1'b1; a_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_idle", 32'(a_state), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check("abort_no_resp", 32'(a_rvalid), 32'd0);
      @(posedge clk); #1;
    end
    do_access(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h55AA55AA, 1'b1);

    // 5: instance B, no wait states, ReqValidM held through back-to-back loads
    b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h4; b_wdata = 32'hCAFE0001; b_be = 4'hF;
    @(posedge clk); #1;
    check("b_store_resp", 32'(b_rvalid), 32'd1);
    check("b_store_err", 32'(b_err), 32'd0);
    b_valid = 1'b0;
    @(posedge clk); #1;
    check("b_idle_ready", 32'(b_ready), 32'd1);
    b_valid = 1'b1; b_we = 1'b0; b_addr = 32'h4; b_be = 4'h0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("b2b_rvalid", 32'(b_rvalid), 32'((c % 2) == 0));
      check("b2b_ready", 32'(b_ready), 32'((c % 2) == 1));
      if ((c % 2) == 0) begin
        check("b2b_rdata", b_rdata, 32'hCAFE0001);
        check("b2b_stall", 32'(b_stall), 32'd0);
      end
    end
    b_valid = 1'b0;
    @(posedge clk); #1;
    check("b_end_rvalid", 32'(b_rvalid), 32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
